bip_checker_multilane: RTL

BIP_CHECKER_MULTILANE -- requirements
Module: bip_checker_multilane

---
 rtl/bip_checker_multilane_if.sv | 36 +++
 rtl/bip_checker_multilane.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/bip_checker_multilane_if.sv
// Block stream, counter-control and comparison-result signals of the multilane BIP checker.
// The slave modport is the checker side; the master modport is the source/consumer side.
interface bip_checker_multilane_if #(
    parameter int LEN_CODED_BLOCK = 66,
    parameter int NB_BIP          = 8,
    parameter int NB_LANE_ID      = 5,
    parameter int NB_ERR_CNT      = 16
);
    logic [LEN_CODED_BLOCK-1:0] i_data;
    logic                       i_valid;
    logic                       i_enable;
    logic [NB_LANE_ID-1:0]      i_lane_id;
    logic                       i_am_flag;
    logic                       i_clear_counters;
    logic [NB_LANE_ID-1:0]      i_rd_lane;

    logic                       o_check_valid;
    logic [NB_LANE_ID-1:0]      o_check_lane;
    logic                       o_bip_error;
    logic [3:0]                 o_bip_err_bits;
    logic                       o_bip7_mismatch;
    logic [NB_BIP-1:0]          o_calc_bip3;
    logic [NB_ERR_CNT-1:0]      o_rd_err_count;

    modport master (
        output i_data, i_valid, i_enable, i_lane_id, i_am_flag, i_clear_counters, i_rd_lane,
        input  o_check_valid, o_check_lane, o_bip_error, o_bip_err_bits, o_bip7_mismatch,
               o_calc_bip3, o_rd_err_count
    );

    modport slave (
        input  i_data, i_valid, i_enable, i_lane_id, i_am_flag, i_clear_counters, i_rd_lane,
        output o_check_valid, o_check_lane, o_bip_error, o_bip_err_bits, o_bip7_mismatch,
               o_calc_bip3, o_rd_err_count
    );
endinterface

// File: rtl/bip_checker_multilane.sv
// Per-lane BIP3 accumulation over time-interleaved PCS lanes, checked against the BIP3/BIP7
// carried in each alignment marker, with saturating per-lane error counters and a read port.
module bip_checker_multilane #(
    parameter int LEN_CODED_BLOCK = 66,
    parameter int NB_BIP          = 8,
    parameter int NB_LANES        = 20,
    parameter int NB_LANE_ID      = 5,
    parameter int NB_ERR_CNT      = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    bip_checker_multilane_if.slave bus
);
    localparam int                    NB_GRP    = (LEN_CODED_BLOCK - 2) / 8;
    localparam logic [NB_LANE_ID:0]   LANES_LIM = NB_LANES[NB_LANE_ID:0];
    localparam logic [NB_ERR_CNT-1:0] CNT_MAX   = '1;
    localparam logic [NB_BIP-1:0]     ALL_ONES  = '1;

    function automatic logic [NB_BIP-1:0] contribution(input logic [LEN_CODED_BLOCK-1:0] d);
        logic [NB_BIP-1:0] c;
        c = '0;
        for (int k = 0; k < NB_GRP; k++)
            for (int j = 0; j < NB_BIP; j++)
                c[j] = c[j] ^ d[LEN_CODED_BLOCK-1-(2+j+8*k)];
        // sync header bits fold into BIP bits 3 and 4
        c[3] = c[3] ^ d[LEN_CODED_BLOCK-1];
        c[4] = c[4] ^ d[LEN_CODED_BLOCK-2];
        return c;
    endfunction

    function automatic logic [NB_BIP-1:0] field_at(input logic [LEN_CODED_BLOCK-1:0] d,
                                                   input int pos);
        logic [NB_BIP-1:0] f;
        for (int j = 0; j < NB_BIP; j++)
            f[j] = d[LEN_CODED_BLOCK-1-(pos+j)];
        return f;
    endfunction

    function automatic logic [3:0] popcount(input logic [NB_BIP-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NB_BIP; i++)
            n = n + 4'(v[i]);
        return n;
    endfunction

    logic [NB_BIP-1:0]     acc_q [NB_LANES];
    logic [NB_BIP-1:0]     acc_d [NB_LANES];
    logic [NB_ERR_CNT-1:0] cnt_q [NB_LANES];
    logic [NB_ERR_CNT-1:0] cnt_d [NB_LANES];
    logic [NB_LANES-1:0]   armed_q, armed_d;

    logic                  check_valid_q, check_valid_d;
    logic [NB_LANE_ID-1:0] check_lane_q, check_lane_d;
    logic                  bip_error_q, bip_error_d;
    logic [3:0]            err_bits_q, err_bits_d;
    logic                  bip7_mm_q, bip7_mm_d;
    logic [NB_BIP-1:0]     calc_q, calc_d;
    logic [NB_ERR_CNT-1:0] rd_cnt_q, rd_cnt_d;

    logic                  accept;
    logic                  do_cmp;
    logic [NB_BIP-1:0]     contrib;
    logic [NB_BIP-1:0]     rx_bip3;
    logic [NB_BIP-1:0]     rx_bip7;
    logic [NB_BIP-1:0]     acc_sel;
    logic [3:0]            diff_bits;
    logic [NB_ERR_CNT:0]   cnt_sum;

    assign accept    = bus.i_valid && bus.i_enable && ({1'b0, bus.i_lane_id} < LANES_LIM);
    assign contrib   = contribution(bus.i_data);
    assign rx_bip3   = field_at(bus.i_data, 26);
    assign rx_bip7   = field_at(bus.i_data, 58);
    assign acc_sel   = acc_q[bus.i_lane_id];
    assign diff_bits = popcount(acc_sel ^ rx_bip3);
    assign do_cmp    = accept && bus.i_am_flag && armed_q[bus.i_lane_id];
    assign cnt_sum   = {1'b0, cnt_q[bus.i_lane_id]} + (NB_ERR_CNT+1)'(diff_bits);

    always_comb begin
        acc_d         = acc_q;
        armed_d       = armed_q;
        cnt_d         = cnt_q;
        check_valid_d = 1'b0;
        bip_error_d   = 1'b0;
        bip7_mm_d     = 1'b0;
        check_lane_d  = check_lane_q;
        err_bits_d    = err_bits_q;
        calc_d        = calc_q;

        if (accept) begin
            if (bus.i_am_flag) begin
                acc_d[bus.i_lane_id]   = ALL_ONES ^ contrib;
                armed_d[bus.i_lane_id] = 1'b1;
            end else begin
                acc_d[bus.i_lane_id] = acc_sel ^ contrib;
            end
        end

        if (do_cmp) begin
            check_valid_d        = 1'b1;
            check_lane_d         = bus.i_lane_id;
            err_bits_d           = diff_bits;
            bip_error_d          = (diff_bits != 4'd0);
            bip7_mm_d            = (rx_bip7 != ~rx_bip3);
            calc_d               = acc_sel;
            cnt_d[bus.i_lane_id] = cnt_sum[NB_ERR_CNT] ? CNT_MAX : cnt_sum[NB_ERR_CNT-1:0];
        end

        if (bus.i_clear_counters) begin
            for (int l = 0; l < NB_LANES; l++)
                cnt_d[l] = '0;
        end

        rd_cnt_d = ({1'b0, bus.i_rd_lane} < LANES_LIM) ? cnt_q[bus.i_rd_lane] : '0;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int l = 0; l < NB_LANES; l++) begin
                acc_q[l] <= ALL_ONES;
                cnt_q[l] <= '0;
            end
            armed_q       <= '0;
            check_valid_q <= 1'b0;
            check_lane_q  <= '0;
            bip_error_q   <= 1'b0;
            err_bits_q    <= '0;
            bip7_mm_q     <= 1'b0;
            calc_q        <= '0;
            rd_cnt_q      <= '0;
        end else begin
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            armed_q       <= armed_d;
            check_valid_q <= check_valid_d;
            check_lane_q  <= check_lane_d;
            bip_error_q   <= bip_error_d;
            err_bits_q    <= err_bits_d;
            bip7_mm_q     <= bip7_mm_d;
            calc_q        <= calc_d;
            rd_cnt_q      <= rd_cnt_d;
        end
    end

    assign bus.o_check_valid   = check_valid_q;
    assign bus.o_check_lane    = check_lane_q;
    assign bus.o_bip_error     = bip_error_q;
    assign bus.o_bip_err_bits  = err_bits_q;
    assign bus.o_bip7_mismatch = bip7_mm_q;
    assign bus.o_calc_bip3     = calc_q;
    assign bus.o_rd_err_count  = rd_cnt_q;
endmodule
